mips_cpu_wb_scheduler: RTL

//  Writeback scheduler for the register file's single write port. Merges ALU results and
//  in-order load returns into one registered write stream (regwrite/writereg/writedata/opcode/vaddr).

---
 rtl/mips_cpu_wb_scheduler_if.sv | 39 +++
 rtl/mips_cpu_wb_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_wb_scheduler_if.sv
// Writeback bus between the issue/memory side (master) and the writeback scheduler (slave):
// ALU requests, load issue/return and the registered register-file write stream.
interface mips_cpu_wb_scheduler_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;

  logic        ld_issue;
  logic        ld_issue_ready;
  logic [4:0]  ld_issue_reg;

  logic        ld_valid;
  logic [31:0] ld_data;
  logic [5:0]  ld_opcode;
  logic [1:0]  ld_vaddr;

  logic        regwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic [5:0]  opcode;
  logic [1:0]  vaddr;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output ld_issue, ld_issue_reg,
    output ld_valid, ld_data, ld_opcode, ld_vaddr,
    input  alu_ready, ld_issue_ready,
    input  regwrite, writereg, writedata, opcode, vaddr
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  ld_issue, ld_issue_reg,
    input  ld_valid, ld_data, ld_opcode, ld_vaddr,
    output alu_ready, ld_issue_ready,
    output regwrite, writereg, writedata, opcode, vaddr
  );
endinterface

// File: rtl/mips_cpu_wb_scheduler.sv
// Register-file writeback scheduler: load returns win the write port, ALU results queue behind them.
// Define WB_BYPASS_EN to forward non-partial writeback results to decode instead of stalling.
module mips_cpu_wb_scheduler #(
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int MAX_LOADS      = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  mips_cpu_wb_scheduler_if.slave         wb,
  input  logic [4:0]                     readreg1,
  input  logic [4:0]                     readreg2,
  output logic                           hazard,
  output logic [$clog2(MAX_LOADS+1)-1:0] outstanding,
  output logic                           err,
  output logic                           byp_valid1,
  output logic                           byp_valid2,
  output logic [31:0]                    byp_data
);

  localparam int OW = $clog2(MAX_LOADS + 1);
  localparam int CW = $clog2(ALU_FIFO_DEPTH + 1);
  localparam logic [OW-1:0] LD_LIMIT  = OW'(MAX_LOADS);
  localparam logic [CW-1:0] FIFO_FULL = CW'(ALU_FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } alu_req_t;

  // Both queues are shift registers: entry 0 is always the head.
  alu_req_t      fifo_q [ALU_FIFO_DEPTH];
  logic [CW-1:0] fifo_cnt;
  logic [4:0]    dq_q   [MAX_LOADS];
  logic [OW-1:0] ld_cnt;
  logic [31:0]   busy;

  logic          regwrite_q;
  logic [4:0]    writereg_q;
  logic [31:0]   writedata_q;
  logic [5:0]    opcode_q;
  logic [1:0]    vaddr_q;
  logic          err_q;

  logic          alu_ready_c, issue_ready_c;
  logic          ld_win, ld_orphan, fifo_win, alu_direct, alu_enq;
  logic          issue_ok, issue_bad;
  logic [CW-1:0] fifo_wpos;
  logic [OW-1:0] dq_wpos;

  assign alu_ready_c   = (fifo_cnt != FIFO_FULL);
  assign issue_ready_c = (ld_cnt < LD_LIMIT) &&
                         (wb.ld_issue_reg == 5'd0 || !busy[wb.ld_issue_reg]);

  // A return with nothing in flight has no destination, so it is flagged and never wins the port.
  assign ld_win     = wb.ld_valid && (ld_cnt != '0);
  assign ld_orphan  = wb.ld_valid && (ld_cnt == '0);
  assign fifo_win   = !ld_win && (fifo_cnt != '0);
  assign alu_direct = !ld_win && (fifo_cnt == '0) && wb.alu_valid;
  assign alu_enq    = wb.alu_valid && alu_ready_c && !alu_direct;
  assign issue_ok   = wb.ld_issue && issue_ready_c;
  assign issue_bad  = wb.ld_issue && !issue_ready_c;

  assign fifo_wpos = fifo_win ? fifo_cnt - CW'(1) : fifo_cnt;
  assign dq_wpos   = ld_win   ? ld_cnt   - OW'(1) : ld_cnt;

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset lives inside the clocked block; all state uses <= so every
    // update below sees the pre-edge values computed by the combinational logic above.
    if (!reset_n) begin
      regwrite_q  <= 1'b0;
      writereg_q  <= 5'd0;
      writedata_q <= 32'd0;
      opcode_q    <= 6'd0;
      vaddr_q     <= 2'd0;
      err_q       <= 1'b0;
      fifo_cnt    <= '0;
      ld_cnt      <= '0;
      busy        <= '0;
    end else begin
      if (ld_win) begin
        regwrite_q  <= 1'b1;
        writereg_q  <= dq_q[0];
        writedata_q <= wb.ld_data;
        opcode_q    <= wb.ld_opcode;
        vaddr_q     <= wb.ld_vaddr;
      end else if (fifo_win) begin
        regwrite_q  <= 1'b1;
        writereg_q  <= fifo_q[0].rd;
        writedata_q <= fifo_q[0].data;
        opcode_q    <= 6'd0;
        vaddr_q     <= 2'd0;
      end else if (alu_direct) begin
        regwrite_q  <= 1'b1;
        writereg_q  <= wb.alu_reg;
        writedata_q <= wb.alu_data;
        opcode_q    <= 6'd0;
        vaddr_q     <= 2'd0;
      end else begin
        regwrite_q  <= 1'b0;
      end

      if (ld_orphan || issue_bad) err_q <= 1'b1;

      fifo_cnt <= fifo_cnt + CW'(alu_enq) - CW'(fifo_win);
      ld_cnt   <= ld_cnt + OW'(issue_ok) - OW'(ld_win);

      // Clear before set: an accepted issue can never target the returning register,
      // because ld_issue_ready already refused any register that is still busy.
      if (ld_win) busy[dq_q[0]] <= 1'b0;
      if (issue_ok && wb.ld_issue_reg != 5'd0) busy[wb.ld_issue_reg] <= 1'b1;
    end
  end

  // NOTE: queue payloads are deliberately not reset; the counters define which entries are
  // valid, and nothing (hazard included) looks past them.
  always_ff @(posedge clk) begin
    if (fifo_win) begin
      for (int i = 0; i < ALU_FIFO_DEPTH - 1; i++) fifo_q[i] <= fifo_q[i+1];
    end
    if (alu_enq) begin
      for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
        if (CW'(i) == fifo_wpos) fifo_q[i] <= {wb.alu_reg, wb.alu_data};
      end
    end

    if (ld_win) begin
      for (int i = 0; i < MAX_LOADS - 1; i++) dq_q[i] <= dq_q[i+1];
    end
    if (issue_ok) begin
      for (int i = 0; i < MAX_LOADS; i++) begin
        if (OW'(i) == dq_wpos) dq_q[i] <= wb.ld_issue_reg;
      end
    end
  end

  logic [1:0] fifo_hit;
  logic [1:0] wb_hit;
  logic       wb_bypassable;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fifo_hit = 2'b00;
    for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
      if (CW'(i) < fifo_cnt) begin
        if (fifo_q[i].rd == readreg1) fifo_hit[0] = 1'b1;
        if (fifo_q[i].rd == readreg2) fifo_hit[1] = 1'b1;
      end
    end
  end

  assign wb_hit[0] = regwrite_q && (writereg_q == readreg1);
  assign wb_hit[1] = regwrite_q && (writereg_q == readreg2);

`ifdef WB_BYPASS_EN
  // Partial loads need the old register contents merged in the regfile, so they cannot forward.
  function automatic logic is_partial_load(input logic [5:0] op);
    return op inside {6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100010, 6'b100110};
  endfunction

  assign wb_bypassable = !is_partial_load(opcode_q);
  assign byp_valid1    = (readreg1 != 5'd0) && wb_hit[0] && wb_bypassable;
  assign byp_valid2    = (readreg2 != 5'd0) && wb_hit[1] && wb_bypassable;
  assign byp_data      = writedata_q;
`else
  assign wb_bypassable = 1'b0;
  assign byp_valid1    = 1'b0;
  assign byp_valid2    = 1'b0;
  assign byp_data      = 32'd0;
`endif

  assign hazard =
    ((readreg1 != 5'd0) && (busy[readreg1] || fifo_hit[0] || (wb_hit[0] && !wb_bypassable))) ||
    ((readreg2 != 5'd0) && (busy[readreg2] || fifo_hit[1] || (wb_hit[1] && !wb_bypassable)));

  assign wb.alu_ready      = alu_ready_c;
  assign wb.ld_issue_ready = issue_ready_c;
  assign wb.regwrite       = regwrite_q;
  assign wb.writereg       = writereg_q;
  assign wb.writedata      = writedata_q;
  assign wb.opcode         = opcode_q;
  assign wb.vaddr          = vaddr_q;
  assign outstanding       = ld_cnt;
  assign err               = err_q;

endmodule
